affine_loop_controller: RTL and testbench
=========================================

AFFINE_LOOP_CONTROLLER -- requirements
Module: affine_loop_controller

Interface
REQ-001 Parameter EXTENT_0, default 1, trip count of the outermost loop (ctrl_vars[0]); legal range 1..65535.
REQ-002 Parameter EXTENT_1, default 64, trip count of the middle loop (ctrl_vars[1]); legal range 1..65535.
REQ-003 Parameter EXTENT_2, default 64, trip count of the innermost loop (ctrl_vars[2]); legal range 1..65535.
REQ-004 Parameter II, default 1, cycles between consecutive issues; legal range 1..255.
REQ-005 Parameter START_DELAY, default 0, idle cycles between flush and first issue; legal range 0..65535.
REQ-006 clk  input  1  sole clock; all state updates on the rising edge.
REQ-007 rst_n  input  1  synchronous, active-low reset, sampled on the clk rising edge.
REQ-008 flush  input  1  restart pulse: abandon the current nest and begin a new one.
REQ-009 stall  input  1  freeze request from downstream.
REQ-010 en  output  1  issue strobe; drives a unified buffer's wen or ren.
REQ-011 ctrl_vars  output  16 x [2:0]  loop indices of the current issue; [0] outermost, [2] innermost.
REQ-012 done  output  1  sticky flag: all EXTENT_0*EXTENT_1*EXTENT_2 issues are complete.

Function
REQ-013 The FSM SHALL have four states: IDLE, DELAY, RUN, DONE.
REQ-014 flush SHALL move the FSM from any state to DELAY, load the delay counter with START_DELAY, clear ctrl_vars to 0, clear the II counter and clear done.
REQ-015 In DELAY the counter SHALL decrement each unstalled cycle; at zero the FSM SHALL enter RUN, so the first en occurs in cycle t+1+START_DELAY for a flush sampled in cycle t.
REQ-016 In RUN, en SHALL equal (II counter == 0) AND NOT stall; en is combinational only in its stall gating.
REQ-017 When en is high, ctrl_vars SHALL present the current indices and SHALL advance at the next edge, innermost first with carry: [2] wraps EXTENT_2-1 -> 0 and increments [1]; [1] wraps EXTENT_1-1 -> 0 and increments [0].
REQ-018 The II counter SHALL count 0..II-1 and wrap, so unstalled issues are exactly II cycles apart.
REQ-019 The issue with all indices at their maxima SHALL move the FSM to DONE at the next edge; done SHALL be 1 from that edge on, and en SHALL stay 0 until flush.
REQ-020 While stall is 1, all state (FSM, delay counter, II counter, ctrl_vars) SHALL hold; the pending issue SHALL occur in the first cycle stall is 0.
REQ-021 Between issues, ctrl_vars SHALL hold the value of the next pending issue.
REQ-022 Counter arithmetic SHALL be 16-bit unsigned; an extent of 1 SHALL hold that index at 0 permanently.
REQ-023 flush SHALL take priority over stall; a flush in the same cycle as the final issue SHALL win, with done staying 0.
REQ-024 In IDLE, en and done SHALL be 0.

Reset
REQ-025 rst_n=0 at an edge SHALL force IDLE, ctrl_vars=0, II counter=0, delay counter=0, en=0 and done=0, overriding flush and stall.
REQ-026 Reset asserted mid-nest SHALL abandon the nest; no further en until a flush after reset release.

Configuration
REQ-027 With macro AFFINE_LOOP_CONTROLLER_STALL_EN defined, stall SHALL behave per REQ-016/REQ-020.
REQ-028 Without AFFINE_LOOP_CONTROLLER_STALL_EN, stall SHALL be ignored (treated as 0); the port list SHALL be unchanged.

Verification
REQ-029 Scenario: EXTENT=(1,4,4), II=1, START_DELAY=2, flush at cycle 10 -> en high cycles 13..28; ctrl_vars[2] cycles 0,1,2,3; ctrl_vars[1] steps every 4 issues; done=1 from cycle 29.
REQ-030 Scenario: EXTENT=(2,2,3), II=3, START_DELAY=0, flush at cycle 5 -> 12 issues at cycles 6,9,...,39; the last issue shows ctrl_vars=(1,1,2); done at cycle 40.
REQ-031 Scenario: as REQ-029 with stall high cycles 15..17 (macro defined) -> en low 15..17; the issue pending at 15 (ctrl_vars[2]=2) occurs at 18; last issue at 31; done at 32.
REQ-032 Scenario: as REQ-031 with the macro undefined -> timing identical to REQ-029.
REQ-033 Scenario: as REQ-029 with a second flush at cycle 20 -> en low 21..22, restart at 23 with ctrl_vars=(0,0,0), 16 issues through cycle 38.
REQ-034 Scenario: as REQ-029 with rst_n=0 at cycle 18 -> en low and ctrl_vars=0 from cycle 18; no en until the next flush; done=0.

Source files
------------

// File: rtl/affine_loop_controller_if.sv
// Issue-side bundle of the affine loop controller: restart/freeze requests in, issue strobe,
// loop indices and completion flag out.
interface affine_loop_controller_if;
  logic             flush;
  logic             stall;
  logic             en;
  logic [2:0][15:0] ctrl_vars;
  logic             done;

  modport master (
    output flush,
    output stall,
    input  en,
    input  ctrl_vars,
    input  done
  );

  modport slave (
    input  flush,
    input  stall,
    output en,
    output ctrl_vars,
    output done
  );
endinterface

// File: rtl/affine_loop_controller.sv
// Three-deep affine loop nest issuing one access every II cycles after a programmable start delay.
// Define AFFINE_LOOP_CONTROLLER_STALL_EN to honour the stall input; otherwise it is ignored.
module affine_loop_controller #(
  parameter int unsigned EXTENT_0    = 1,
  parameter int unsigned EXTENT_1    = 64,
  parameter int unsigned EXTENT_2    = 64,
  parameter int unsigned II          = 1,
  parameter int unsigned START_DELAY = 0
) (
  input logic                      clk,
  input logic                      rst_n,
  affine_loop_controller_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StDelay, StRun, StDone} state_e;

  localparam logic [15:0] Max0     = 16'(EXTENT_0 - 1);
  localparam logic [15:0] Max1     = 16'(EXTENT_1 - 1);
  localparam logic [15:0] Max2     = 16'(EXTENT_2 - 1);
  localparam logic [7:0]  IiMax    = 8'(II - 1);
  localparam logic [15:0] DelayLd  = 16'(START_DELAY);
  // With no start delay the first issue follows the flush directly.
  localparam state_e      FlushDst = (START_DELAY == 0) ? StRun : StDelay;

  state_e           state_q;
  logic [15:0]      delay_q;
  logic [7:0]       ii_q;
  logic [2:0][15:0] idx_q;
  logic [2:0][15:0] idx_d;
  logic             done_q;
  logic             stall_eff;
  logic             issue;
  logic             last;

`ifdef AFFINE_LOOP_CONTROLLER_STALL_EN
  assign stall_eff = bus.stall;
`else
  logic unused_stall;
  assign unused_stall = bus.stall;
  assign stall_eff    = 1'b0;
`endif

  assign issue = (state_q == StRun) && (ii_q == 8'd0) && !stall_eff;
  assign last  = (idx_q[0] == Max0) && (idx_q[1] == Max1) && (idx_q[2] == Max2);

  // Innermost index first, carrying outward.
  always_comb begin
    idx_d = idx_q;
    if (idx_q[2] == Max2) begin
      idx_d[2] = 16'd0;
      if (idx_q[1] == Max1) begin
        idx_d[1] = 16'd0;
        idx_d[0] = (idx_q[0] == Max0) ? 16'd0 : idx_q[0] + 16'd1;
      end else begin
        idx_d[1] = idx_q[1] + 16'd1;
      end
    end else begin
      idx_d[2] = idx_q[2] + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      delay_q <= 16'd0;
      ii_q    <= 8'd0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else if (bus.flush) begin
      state_q <= FlushDst;
      delay_q <= DelayLd;
      ii_q    <= 8'd0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else if (!stall_eff) begin
      unique case (state_q)
        StIdle: begin
        end
        StDelay: begin
          delay_q <= delay_q - 16'd1;
          if (delay_q <= 16'd1) begin
            state_q <= StRun;
          end
        end
        StRun: begin
          ii_q <= (ii_q == IiMax) ? 8'd0 : ii_q + 8'd1;
          if (issue) begin
            idx_q <= idx_d;
            if (last) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end
          end
        end
        StDone: begin
        end
      endcase
    end
  end

  assign bus.en        = issue;
  assign bus.ctrl_vars = idx_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_affine_loop_controller.sv
// Directed bench for affine_loop_controller: two instances cover the (1,4,4)/II=1/delay=2 and
// (2,2,3)/II=3/delay=0 nests; cycle c counts falling edges from the start of each scenario.
module tb_affine_loop_controller;
  logic clk;
  logic rst_a;
  logic rst_b;
  int   checks;
  int   errors;

  affine_loop_controller_if ifa ();
  affine_loop_controller_if ifb ();

  affine_loop_controller #(
    .EXTENT_0(1), .EXTENT_1(4), .EXTENT_2(4), .II(1), .START_DELAY(2)
  ) dut_a (
    .clk  (clk),
    .rst_n(rst_a),
    .bus  (ifa.slave)
  );

  affine_loop_controller #(
    .EXTENT_0(2), .EXTENT_1(2), .EXTENT_2(3), .II(3), .START_DELAY(0)
  ) dut_b (
    .clk  (clk),
    .rst_n(rst_b),
    .bus  (ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic reset_a();
    rst_a = 1'b0; ifa.flush = 1'b0; ifa.stall = 1'b0;
    repeat (2) @(negedge clk);
    rst_a = 1'b1;
  endtask

  task automatic test_reset();
    rst_a = 1'b0; rst_b = 1'b0;
    ifa.flush = 1'b1; ifa.stall = 1'b1; ifb.flush = 1'b1; ifb.stall = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (ifa.en !== 1'b0 || ifa.done !== 1'b0 || ifa.ctrl_vars !== '0) begin
      errors++;
      $display("FAIL reset_a en=%b done=%b cv=%h required 0/0/0", ifa.en, ifa.done, ifa.ctrl_vars);
    end
    checks++;
    if (ifb.en !== 1'b0 || ifb.done !== 1'b0 || ifb.ctrl_vars !== '0) begin
      errors++;
      $display("FAIL reset_b en=%b done=%b cv=%h required 0/0/0", ifb.en, ifb.done, ifb.ctrl_vars);
    end
    ifa.flush = 1'b0; ifa.stall = 1'b0; ifb.flush = 1'b0;
    rst_a = 1'b1; rst_b = 1'b1;
    repeat (3) begin
      @(negedge clk); #1;
      checks++;
      if (ifa.en !== 1'b0 || ifa.done !== 1'b0 || ifb.en !== 1'b0 || ifb.done !== 1'b0) begin
        errors++;
        $display("FAIL idle en=%b/%b done=%b/%b required all 0", ifa.en, ifb.en, ifa.done, ifb.done);
      end
    end
  endtask

  task automatic test_nest_ii1();
    logic exp_en;
    logic exp_done;
    logic [2:0][15:0] exp_cv;
    int k;
    reset_a();
    for (int c = 0; c <= 34; c++) begin
      @(negedge clk);
      ifa.flush = (c == 10);
      #1;
      exp_en = (c >= 13 && c <= 28);
      exp_done = (c >= 29);
      checks++;
      if (ifa.en !== exp_en) begin
        errors++; $display("FAIL ii1_en c=%0d got %b required %b", c, ifa.en, exp_en);
      end
      checks++;
      if (ifa.done !== exp_done) begin
        errors++; $display("FAIL ii1_done c=%0d got %b required %b", c, ifa.done, exp_done);
      end
      if (exp_en) begin
        k = c - 13;
        exp_cv[0] = 16'd0; exp_cv[1] = 16'(k / 4); exp_cv[2] = 16'(k % 4);
        checks++;
        if (ifa.ctrl_vars !== exp_cv) begin
          errors++; $display("FAIL ii1_cv c=%0d got %h required %h", c, ifa.ctrl_vars, exp_cv);
        end
      end
    end
    ifa.flush = 1'b0;
  endtask

  task automatic test_stall();
    logic exp_en;
    logic exp_done;
    logic [2:0][15:0] exp_cv;
    int k;
    reset_a();
    for (int c = 0; c <= 36; c++) begin
      @(negedge clk);
      ifa.flush = (c == 10);
      ifa.stall = (c >= 15 && c <= 17);
      #1;
`ifdef AFFINE_LOOP_CONTROLLER_STALL_EN
      exp_en = (c >= 13 && c <= 14) || (c >= 18 && c <= 31);
      exp_done = (c >= 32);
      k = (c < 15) ? c - 13 : c - 16;
      if (c == 15) begin
        checks++;
        if (ifa.ctrl_vars[2] !== 16'd2) begin
          errors++; $display("FAIL stall_pending got %0d required 2", ifa.ctrl_vars[2]);
        end
      end
`else
      exp_en = (c >= 13 && c <= 28);
      exp_done = (c >= 29);
      k = c - 13;
`endif
      checks++;
      if (ifa.en !== exp_en) begin
        errors++; $display("FAIL stall_en c=%0d got %b required %b", c, ifa.en, exp_en);
      end
      checks++;
      if (ifa.done !== exp_done) begin
        errors++; $display("FAIL stall_done c=%0d got %b required %b", c, ifa.done, exp_done);
      end
      if (exp_en) begin
        exp_cv[0] = 16'd0; exp_cv[1] = 16'(k / 4); exp_cv[2] = 16'(k % 4);
        checks++;
        if (ifa.ctrl_vars !== exp_cv) begin
          errors++; $display("FAIL stall_cv c=%0d got %h required %h", c, ifa.ctrl_vars, exp_cv);
        end
      end
    end
    ifa.flush = 1'b0; ifa.stall = 1'b0;
  endtask

  task automatic test_reflush();
    logic exp_en;
    logic exp_done;
    logic [2:0][15:0] exp_cv;
    int k;
    reset_a();
    for (int c = 0; c <= 42; c++) begin
      @(negedge clk);
      ifa.flush = (c == 10 || c == 20);
      #1;
      exp_en = (c >= 13 && c <= 20) || (c >= 23 && c <= 38);
      exp_done = (c >= 39);
      k = (c <= 20) ? c - 13 : c - 23;
      checks++;
      if (ifa.en !== exp_en) begin
        errors++; $display("FAIL reflush_en c=%0d got %b required %b", c, ifa.en, exp_en);
      end
      checks++;
      if (ifa.done !== exp_done) begin
        errors++; $display("FAIL reflush_done c=%0d got %b required %b", c, ifa.done, exp_done);
      end
      if (exp_en || c == 21 || c == 22) begin
        if (!exp_en) k = 0;
        exp_cv[0] = 16'd0; exp_cv[1] = 16'(k / 4); exp_cv[2] = 16'(k % 4);
        checks++;
        if (ifa.ctrl_vars !== exp_cv) begin
          errors++; $display("FAIL reflush_cv c=%0d got %h required %h", c, ifa.ctrl_vars, exp_cv);
        end
      end
    end
    ifa.flush = 1'b0;
  endtask

  task automatic test_flush_on_final();
    logic exp_en;
    logic exp_done;
    logic [2:0][15:0] exp_cv;
    int k;
    reset_a();
    for (int c = 0; c <= 50; c++) begin
      @(negedge clk);
      ifa.flush = (c == 10 || c == 28);
      #1;
      exp_en = (c >= 13 && c <= 28) || (c >= 31 && c <= 46);
      exp_done = (c >= 47);
      k = (c <= 28) ? c - 13 : c - 31;
      checks++;
      if (ifa.en !== exp_en) begin
        errors++; $display("FAIL final_en c=%0d got %b required %b", c, ifa.en, exp_en);
      end
      checks++;
      if (ifa.done !== exp_done) begin
        errors++; $display("FAIL final_done c=%0d got %b required %b", c, ifa.done, exp_done);
      end
      if (exp_en) begin
        exp_cv[0] = 16'd0; exp_cv[1] = 16'(k / 4); exp_cv[2] = 16'(k % 4);
        checks++;
        if (ifa.ctrl_vars !== exp_cv) begin
          errors++; $display("FAIL final_cv c=%0d got %h required %h", c, ifa.ctrl_vars, exp_cv);
        end
      end
    end
    ifa.flush = 1'b0;
  endtask

  // rst_n driven low in cycles 17..19 is sampled at the edges starting cycles 18..20.
  task automatic test_reset_mid_nest();
    logic exp_en;
    logic [2:0][15:0] exp_cv;
    int k;
    reset_a();
    for (int c = 0; c <= 40; c++) begin
      @(negedge clk);
      ifa.flush = (c == 10);
      rst_a = !(c >= 17 && c <= 19);
      #1;
      exp_en = (c >= 13 && c <= 17);
      k = c - 13;
      checks++;
      if (ifa.en !== exp_en) begin
        errors++; $display("FAIL rstmid_en c=%0d got %b required %b", c, ifa.en, exp_en);
      end
      checks++;
      if (ifa.done !== 1'b0) begin
        errors++; $display("FAIL rstmid_done c=%0d got %b required 0", c, ifa.done);
      end
      if (exp_en || c >= 18) begin
        if (!exp_en) k = 0;
        exp_cv[0] = 16'd0; exp_cv[1] = 16'(k / 4); exp_cv[2] = 16'(k % 4);
        checks++;
        if (ifa.ctrl_vars !== exp_cv) begin
          errors++; $display("FAIL rstmid_cv c=%0d got %h required %h", c, ifa.ctrl_vars, exp_cv);
        end
      end
    end
    rst_a = 1'b1;
    ifa.flush = 1'b0;
  endtask

  task automatic test_nest_ii3();
    logic exp_en;
    logic exp_done;
    logic [2:0][15:0] exp_cv;
    int k;
    rst_b = 1'b0; ifb.flush = 1'b0; ifb.stall = 1'b0;
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    for (int c = 0; c <= 45; c++) begin
      @(negedge clk);
      ifb.flush = (c == 5);
      #1;
      exp_en = (c >= 6 && c <= 39 && ((c - 6) % 3 == 0));
      exp_done = (c >= 40);
      k = (c - 6) / 3;
      checks++;
      if (ifb.en !== exp_en) begin
        errors++; $display("FAIL ii3_en c=%0d got %b required %b", c, ifb.en, exp_en);
      end
      checks++;
      if (ifb.done !== exp_done) begin
        errors++; $display("FAIL ii3_done c=%0d got %b required %b", c, ifb.done, exp_done);
      end
      if (exp_en) begin
        exp_cv[0] = 16'(k / 6); exp_cv[1] = 16'((k / 3) % 2); exp_cv[2] = 16'(k % 3);
        checks++;
        if (ifb.ctrl_vars !== exp_cv) begin
          errors++; $display("FAIL ii3_cv c=%0d got %h required %h", c, ifb.ctrl_vars, exp_cv);
        end
      end
    end
    ifb.flush = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_a = 1'b0; rst_b = 1'b0;
    ifa.flush = 1'b0; ifa.stall = 1'b0; ifb.flush = 1'b0; ifb.stall = 1'b0;
    test_reset();
    test_nest_ii1();
    test_stall();
    test_reflush();
    test_flush_on_final();
    test_reset_mid_nest();
    test_nest_ii3();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
